// File: rtl/mc_pkg.sv
// Shared types and encodings for the handshaked multicycle MIPS control FSM.
// Covers state codes, opcode/funct values, datapath mux selects and trap causes.
package mc_pkg;

   typedef enum logic [4:0] {
      S_IDLE     = 5'd0,
      S_FETCH    = 5'd1,
      S_DECODE   = 5'd2,
      S_EXEC_R   = 5'd3,
      S_WB_R     = 5'd4,
      S_JR       = 5'd5,
      S_EXEC_I   = 5'd6,
      S_WB_I     = 5'd7,
      S_MEM_ADDR = 5'd8,
      S_MEM_RD   = 5'd9,
      S_MEM_WB   = 5'd10,
      S_MEM_WR   = 5'd11,
      S_BRANCH   = 5'd12,
      S_JUMP     = 5'd13,
      S_JAL      = 5'd14,
      S_TRAP     = 5'd15
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03, OP_BEQ  = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0A, OP_SLTIU = 6'h0B;
   localparam logic [5:0] OP_ANDI  = 6'h0C, OP_ORI  = 6'h0D, OP_XORI = 6'h0E, OP_LUI  = 6'h0F;
   localparam logic [5:0] OP_LB    = 6'h20, OP_LH   = 6'h21, OP_LW   = 6'h23, OP_LBU  = 6'h24;
   localparam logic [5:0] OP_LHU   = 6'h25, OP_SB   = 6'h28, OP_SH   = 6'h29, OP_SW   = 6'h2B;

   localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_SRA  = 6'h03, F_JR   = 6'h08;
   localparam logic [5:0] F_ADD = 6'h20, F_ADDU = 6'h21, F_SUB = 6'h22, F_SUBU = 6'h23;
   localparam logic [5:0] F_AND = 6'h24, F_OR  = 6'h25, F_XOR  = 6'h26, F_NOR  = 6'h27;
   localparam logic [5:0] F_SLT = 6'h2A, F_SLTU = 6'h2B;

   localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_FUNCT = 4'd2, ALU_AND = 4'd3;
   localparam logic [3:0] ALU_OR  = 4'd4, ALU_XOR = 4'd5, ALU_LUI  = 4'd6, ALU_SLT = 4'd7;
   localparam logic [3:0] ALU_SLTU = 4'd8;

   localparam logic [1:0] RD_RT = 2'b00, RD_RD = 2'b01, RD_RA = 2'b10;
   localparam logic [1:0] SA_PC = 2'b00, SA_REG = 2'b01, SA_SHAMT = 2'b10;
   localparam logic [1:0] SB_REG = 2'b00, SB_FOUR = 2'b01, SB_EXT = 2'b10, SB_EXT2 = 2'b11;
   localparam logic [1:0] PS_ALU = 2'b00, PS_ALUOUT = 2'b01, PS_JT = 2'b10;
   localparam logic [1:0] MR_ALUOUT = 2'b00, MR_MDR = 2'b01, MR_PC = 2'b10;
   localparam logic [1:0] LS_WORD = 2'b00, LS_HALF = 2'b01, LS_BYTE = 2'b10;

   localparam logic [1:0] CAUSE_NONE = 2'b00, CAUSE_ILL = 2'b01, CAUSE_BUS = 2'b10;

   // fetch gates IRWrite/PCWrite with imem_ready at the output stage
   typedef struct packed {
      logic       fetch;
      logic       dmem_req;
      logic       pcwrite;
      logic       pcwritecond;
      logic       memwrite;
      logic       regwrite;
      logic       extop;
      logic       dmextop;
      logic [1:0] pcsource;
      logic [1:0] alusrca;
      logic [1:0] alusrcb;
      logic [1:0] memtoreg;
      logic [1:0] regdst;
      logic [1:0] lsop;
      logic [3:0] aluop;
   } ctl_t;

   function automatic logic is_rfunct(input logic [5:0] f);
      case (f)
         F_SLL, F_SRL, F_SRA, F_ADD, F_ADDU, F_SUB, F_SUBU,
         F_AND, F_OR, F_XOR, F_NOR, F_SLT, F_SLTU: is_rfunct = 1'b1;
         default:                                   is_rfunct = 1'b0;
      endcase
   endfunction

   function automatic logic is_ldst(input logic [5:0] o);
      case (o)
         OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW: is_ldst = 1'b1;
         default:                                                 is_ldst = 1'b0;
      endcase
   endfunction

   function automatic logic [3:0] ialu_op(input logic [5:0] o);
      case (o)
         OP_SLTI:  ialu_op = ALU_SLT;
         OP_SLTIU: ialu_op = ALU_SLTU;
         OP_ANDI:  ialu_op = ALU_AND;
         OP_ORI:   ialu_op = ALU_OR;
         OP_XORI:  ialu_op = ALU_XOR;
         OP_LUI:   ialu_op = ALU_LUI;
         default:  ialu_op = ALU_ADD;
      endcase
   endfunction

   // access size follows the low opcode bits: 11 word, 01 half, 00 byte
   function automatic logic [1:0] lsop_of(input logic [5:0] o);
      case (o[1:0])
         2'b11:   lsop_of = LS_WORD;
         2'b01:   lsop_of = LS_HALF;
         default: lsop_of = LS_BYTE;
      endcase
   endfunction

endpackage

// File: rtl/mc_ctrl_hs_wait.sv
// Memory wait-state counter: counts cycles the awaited ready stays low and
// flags expiry on the cycle that would reach MEM_TIMEOUT.
module mc_wait_timer #(
   parameter int MEM_TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic wait_en,
   output logic expired
);
   import mc_pkg::*;

   localparam logic [7:0] LAST = 8'(MEM_TIMEOUT - 1);

   logic [7:0] cnt_r;

   assign expired = wait_en && (cnt_r == LAST);

   // wait-cycle counter, restarted on every state change
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)          cnt_r <= 8'd0;
      else if (clr)      cnt_r <= 8'd0;
      else if (wait_en)  cnt_r <= cnt_r + 8'd1;
      else               cnt_r <= cnt_r;
   end
endmodule

// File: rtl/mc_ctrl_hs.sv
// Multicycle MIPS main control with req/ready memory handshake, bus-timeout
// watchdog, illegal-opcode trap and retired-instruction counter.
module mc_ctrl_hs #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32,
   parameter int ALUOP_W     = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [5:0]         op,
   input  logic [5:0]         funct,
   input  logic               imem_ready,
   input  logic               dmem_ready,
   output logic               imem_req,
   output logic               dmem_req,
   output logic               IRWrite,
   output logic               PCWrite,
   output logic               PCWriteCond,
   output logic               MemWrite,
   output logic               RegWrite,
   output logic               extop,
   output logic               dmEXTop,
   output logic [1:0]         PCSource,
   output logic [1:0]         ALUSrcA,
   output logic [1:0]         ALUSrcB,
   output logic [1:0]         MemtoReg,
   output logic [1:0]         RegDst,
   output logic [1:0]         lsop,
   output logic [ALUOP_W-1:0] ALUOp,
   output logic               trap,
   output logic [1:0]         trap_cause,
   output logic [CNT_W-1:0]   instret
);
   import mc_pkg::*;

   state_t           state_r, state_nx_s;
   ctl_t             ctl_r;
   logic             trap_r;
   logic [1:0]       cause_r, cause_nx_s;
   logic [CNT_W-1:0] instret_r;
   logic             wait_s, ready_s, expired_s, retire_s;

   // outputs for a state; op/funct are stable IR fields whenever they matter
   function automatic ctl_t decode(input state_t s, input logic [5:0] o, input logic [5:0] f);
      ctl_t c;
      c = '0;
      case (s)
         S_FETCH:    begin c.fetch = 1'b1; c.alusrcb = SB_FOUR; c.aluop = ALU_ADD; c.pcsource = PS_ALU; end
         S_DECODE:   begin c.alusrca = SA_PC; c.alusrcb = SB_EXT2; c.aluop = ALU_ADD; end
         S_EXEC_R:   begin
            c.alusrca = (f == F_SLL || f == F_SRL || f == F_SRA) ? SA_SHAMT : SA_REG;
            c.alusrcb = SB_REG; c.aluop = ALU_FUNCT;
         end
         S_WB_R:     begin c.regwrite = 1'b1; c.regdst = RD_RD; c.memtoreg = MR_ALUOUT; end
         S_JR:       begin
            c.alusrca = SA_REG; c.alusrcb = SB_REG; c.aluop = ALU_ADD;
            c.pcsource = PS_ALU; c.pcwrite = 1'b1;
         end
         S_EXEC_I:   begin
            c.alusrca = SA_REG; c.alusrcb = SB_EXT; c.aluop = ialu_op(o);
            c.extop = (o[5:2] == 4'b0010);
         end
         S_WB_I:     begin c.regwrite = 1'b1; c.regdst = RD_RT; c.memtoreg = MR_ALUOUT; end
         S_MEM_ADDR: begin c.alusrca = SA_REG; c.alusrcb = SB_EXT; c.extop = 1'b1; c.aluop = ALU_ADD; end
         S_MEM_RD:   begin c.dmem_req = 1'b1; c.lsop = lsop_of(o); end
         S_MEM_WR:   begin c.dmem_req = 1'b1; c.memwrite = 1'b1; c.lsop = lsop_of(o); end
         S_MEM_WB:   begin
            c.regwrite = 1'b1; c.regdst = RD_RT; c.memtoreg = MR_MDR;
            c.dmextop = (o == OP_LH) || (o == OP_LB);
         end
         S_BRANCH:   begin
            c.alusrca = SA_REG; c.alusrcb = SB_REG; c.aluop = ALU_SUB;
            c.pcwritecond = 1'b1; c.pcsource = PS_ALUOUT;
         end
         S_JUMP:     begin c.pcwrite = 1'b1; c.pcsource = PS_JT; end
         S_JAL:      begin
            c.pcwrite = 1'b1; c.pcsource = PS_JT; c.regwrite = 1'b1;
            c.regdst = RD_RA; c.memtoreg = MR_PC;
         end
         default:    c = '0;
      endcase
      return c;
   endfunction

   assign wait_s   = (state_r == S_FETCH) || (state_r == S_MEM_RD) || (state_r == S_MEM_WR);
   assign ready_s  = (state_r == S_FETCH) ? imem_ready : dmem_ready;
   assign retire_s = (state_nx_s == S_FETCH) && (state_r != S_IDLE) && (state_r != S_FETCH);

   mc_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wait (
      .clk     (clk),
      .rst     (rst),
      .clr     (state_nx_s != state_r),
      .wait_en (wait_s && !ready_s),
      .expired (expired_s)
   );

   // next-state and trap-cause selection
   always_comb begin
      state_nx_s = state_r;
      cause_nx_s = CAUSE_NONE;
      case (state_r)
         S_IDLE:   state_nx_s = S_FETCH;
         S_FETCH, S_MEM_RD, S_MEM_WR: begin
            if (ready_s) begin
               if (state_r == S_FETCH)       state_nx_s = S_DECODE;
               else if (state_r == S_MEM_RD) state_nx_s = S_MEM_WB;
               else                          state_nx_s = S_FETCH;
            end else if (expired_s) begin
               state_nx_s = S_TRAP;
               cause_nx_s = CAUSE_BUS;
            end else begin
               state_nx_s = state_r;
            end
         end
         S_DECODE: begin
            if (op == OP_RTYPE) begin
               if (funct == F_JR)          state_nx_s = S_JR;
               else if (is_rfunct(funct))  state_nx_s = S_EXEC_R;
               else begin state_nx_s = S_TRAP; cause_nx_s = CAUSE_ILL; end
            end else if (op[5:3] == 3'b001) state_nx_s = S_EXEC_I;
            else if (is_ldst(op))           state_nx_s = S_MEM_ADDR;
            else if (op == OP_BEQ)          state_nx_s = S_BRANCH;
            else if (op == OP_J)            state_nx_s = S_JUMP;
            else if (op == OP_JAL)          state_nx_s = S_JAL;
            else begin state_nx_s = S_TRAP; cause_nx_s = CAUSE_ILL; end
         end
         S_EXEC_R:   state_nx_s = S_WB_R;
         S_EXEC_I:   state_nx_s = S_WB_I;
         S_MEM_ADDR: state_nx_s = op[3] ? S_MEM_WR : S_MEM_RD;
         S_WB_R, S_WB_I, S_MEM_WB, S_BRANCH, S_JUMP, S_JAL, S_JR: state_nx_s = S_FETCH;
         S_TRAP:     state_nx_s = S_TRAP;
         default:    state_nx_s = S_IDLE;
      endcase
   end

   // state, registered control word, trap status and retire counter
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r   <= S_IDLE;
         ctl_r     <= '0;
         trap_r    <= 1'b0;
         cause_r   <= CAUSE_NONE;
         instret_r <= '0;
      end else begin
         state_r <= state_nx_s;
         ctl_r   <= decode(state_nx_s, op, funct);
         trap_r  <= (state_nx_s == S_TRAP);
         if ((state_nx_s == S_TRAP) && (state_r != S_TRAP)) cause_r <= cause_nx_s;
         else                                              cause_r <= cause_r;
         if (retire_s) instret_r <= instret_r + CNT_W'(1);
         else          instret_r <= instret_r;
      end
   end

   assign imem_req    = ctl_r.fetch;
   assign dmem_req    = ctl_r.dmem_req;
   assign IRWrite     = ctl_r.fetch && imem_ready;
   assign PCWrite     = ctl_r.pcwrite || (ctl_r.fetch && imem_ready);
   assign PCWriteCond = ctl_r.pcwritecond;
   assign MemWrite    = ctl_r.memwrite;
   assign RegWrite    = ctl_r.regwrite;
   assign extop       = ctl_r.extop;
   assign dmEXTop     = ctl_r.dmextop;
   assign PCSource    = ctl_r.pcsource;
   assign ALUSrcA     = ctl_r.alusrca;
   assign ALUSrcB     = ctl_r.alusrcb;
   assign MemtoReg    = ctl_r.memtoreg;
   assign RegDst      = ctl_r.regdst;
   assign lsop        = ctl_r.lsop;
   assign ALUOp       = ALUOP_W'(ctl_r.aluop);
   assign trap        = trap_r;
   assign trap_cause  = cause_r;
   assign instret     = instret_r;
endmodule

// File: tb/tb_mc_ctrl_hs.sv
// Directed bench for mc_ctrl_hs: one default instance for instruction flows,
// one with MEM_TIMEOUT=4 for the fetch watchdog.
module tb_mc_ctrl_hs;
   logic clk = 1'b0;
   logic rst, rst4, imem_ready, imem_ready4, dmem_ready;
   logic [5:0] op, funct;

   logic imem_req, dmem_req, IRWrite, PCWrite, PCWriteCond, MemWrite, RegWrite, extop, dmEXTop, trap;
   logic [1:0] PCSource, ALUSrcA, ALUSrcB, MemtoReg, RegDst, lsop, trap_cause;
   logic [3:0] ALUOp;
   logic [31:0] instret;

   logic b_imem_req, b_dmem_req, b_IRWrite, b_PCWrite, b_PCWriteCond, b_MemWrite, b_RegWrite;
   logic b_extop, b_dmEXTop, b_trap;
   logic [1:0] b_PCSource, b_ALUSrcA, b_ALUSrcB, b_MemtoReg, b_RegDst, b_lsop, b_trap_cause;
   logic [3:0] b_ALUOp;
   logic [31:0] b_instret;

   logic [24:0] outs;
   assign outs = {imem_req, dmem_req, IRWrite, PCWrite, PCWriteCond, MemWrite, RegWrite, extop,
                  dmEXTop, PCSource, ALUSrcA, ALUSrcB, MemtoReg, RegDst, lsop, ALUOp};

   int n_vec = 0;
   int n_err = 0;
   int nreq;

   always #5 clk = ~clk;

   mc_ctrl_hs dut (
      .clk(clk), .rst(rst), .op(op), .funct(funct), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
      .imem_req(imem_req), .dmem_req(dmem_req), .IRWrite(IRWrite), .PCWrite(PCWrite),
      .PCWriteCond(PCWriteCond), .MemWrite(MemWrite), .RegWrite(RegWrite), .extop(extop),
      .dmEXTop(dmEXTop), .PCSource(PCSource), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .MemtoReg(MemtoReg), .RegDst(RegDst), .lsop(lsop), .ALUOp(ALUOp), .trap(trap),
      .trap_cause(trap_cause), .instret(instret)
   );

   mc_ctrl_hs #(.MEM_TIMEOUT(4)) dut4 (
      .clk(clk), .rst(rst4), .op(op), .funct(funct), .imem_ready(imem_ready4), .dmem_ready(dmem_ready),
      .imem_req(b_imem_req), .dmem_req(b_dmem_req), .IRWrite(b_IRWrite), .PCWrite(b_PCWrite),
      .PCWriteCond(b_PCWriteCond), .MemWrite(b_MemWrite), .RegWrite(b_RegWrite), .extop(b_extop),
      .dmEXTop(b_dmEXTop), .PCSource(b_PCSource), .ALUSrcA(b_ALUSrcA), .ALUSrcB(b_ALUSrcB),
      .MemtoReg(b_MemtoReg), .RegDst(b_RegDst), .lsop(b_lsop), .ALUOp(b_ALUOp), .trap(b_trap),
      .trap_cause(b_trap_cause), .instret(b_instret)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   initial begin
      rst = 1'b0; rst4 = 1'b0; imem_ready = 1'b1; imem_ready4 = 1'b0; dmem_ready = 1'b0;
      op = 6'h00; funct = 6'h20;
      repeat (3) step();
      chk("rst_outs", 32'(outs), 32'h0);
      chk("rst_instret", instret, 32'd0);
      chk("rst_trap", {29'd0, trap, trap_cause}, 32'd0);
      rst = 1'b1;
      #1 chk("idle_outs", 32'(outs), 32'h0);

      // add: FETCH, DECODE, EXEC_R, WB_R
      step();
      chk("fetch_ctl", {27'd0, imem_req, IRWrite, PCWrite, ALUSrcB}, {27'd0, 3'b111, 2'b01});
      step(); chk("decode_srcb", {30'd0, ALUSrcB}, 32'd3);
      chk("decode_noreq", {31'd0, imem_req}, 32'd0);
      step(); chk("execr_ctl", {26'd0, ALUSrcA, ALUOp}, {26'd0, 2'b01, 4'd2});
      step(); chk("wbr_ctl", {28'd0, RegWrite, 1'b0, RegDst}, {28'd0, 1'b1, 1'b0, 2'b01});
      chk("wbr_instret", instret, 32'd0);
      step(); chk("add_instret", instret, 32'd1);

      // lw with five wait states in MEM_RD
      op = 6'h23;
      step(); step();
      chk("memaddr_ctl", {29'd0, extop, ALUSrcB}, {29'd0, 1'b1, 2'b10});
      step(); nreq = 0;
      if (dmem_req) nreq++;
      chk("lw_lsop", {30'd0, lsop}, 32'd0);
      for (int i = 0; i < 5; i++) begin
         step();
         if (dmem_req) nreq++;
      end
      dmem_ready = 1'b1;
      step(); dmem_ready = 1'b0;
      chk("lw_req_cycles", nreq, 32'd6);
      chk("lw_memwb", {26'd0, dmem_req, RegWrite, MemtoReg, dmEXTop, 1'b0}, {26'd0, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0});
      step(); chk("lw_instret", instret, 32'd2);

      // lh, zero wait states
      op = 6'h21;
      step(); step(); step();
      chk("lh_lsop", {30'd0, lsop}, 32'd1);
      dmem_ready = 1'b1;
      step(); dmem_ready = 1'b0;
      chk("lh_dmext", {31'd0, dmEXTop}, 32'd1);
      step(); chk("lh_instret", instret, 32'd3);

      // jal then beq
      op = 6'h03;
      step(); step();
      chk("jal_ctl", {24'd0, PCWrite, RegWrite, RegDst, MemtoReg, PCSource}, {24'd0, 8'b11_10_10_10});
      step(); chk("jal_instret", instret, 32'd4);
      op = 6'h04;
      step(); step();
      chk("beq_ctl", {24'd0, PCWriteCond, PCWrite, PCSource, ALUOp}, {24'd0, 1'b1, 1'b0, 2'b01, 4'd1});
      step(); chk("beq_instret", instret, 32'd5);

      // ori then sll
      op = 6'h0D;
      step(); step();
      chk("ori_ctl", {25'd0, ALUOp, extop, ALUSrcB}, {25'd0, 4'd4, 1'b0, 2'b10});
      step(); chk("wbi_ctl", {29'd0, RegWrite, RegDst}, {29'd0, 1'b1, 2'b00});
      step();
      op = 6'h00; funct = 6'h00;
      step(); step();
      chk("sll_srca", {30'd0, ALUSrcA}, 32'd2);
      step(); step(); chk("sll_instret", instret, 32'd7);

      // illegal opcode traps and holds until reset
      op = 6'h3F;
      step(); step();
      chk("ill_trap", {29'd0, trap, trap_cause}, {29'd0, 1'b1, 2'b01});
      chk("ill_outs", 32'(outs), 32'h0);
      repeat (3) step();
      chk("ill_hold", {29'd0, trap, trap_cause}, {29'd0, 1'b1, 2'b01});
      rst = 1'b0;
      #1 chk("ill_rst", {29'd0, trap, trap_cause}, 32'd0);
      chk("ill_rst_instret", instret, 32'd0);
      step(); rst = 1'b1;
      step(); chk("refetch", {31'd0, imem_req}, 32'd1);

      // sw with reset asserted mid-access
      op = 6'h2B;
      step(); step(); step();
      chk("sw_ctl", {29'd0, MemWrite, dmem_req, 1'b0}, {29'd0, 1'b1, 1'b1, 1'b0});
      #3 rst = 1'b0;
      #1 chk("sw_rst_drop", {30'd0, MemWrite, dmem_req}, 32'd0);
      step(); rst = 1'b1;
      step(); chk("sw_rst_fetch", {31'd0, imem_req}, 32'd1);

      // fetch timeout on the MEM_TIMEOUT=4 instance
      rst4 = 1'b1;
      step(); chk("to_fetch", {31'd0, b_imem_req}, 32'd1);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("to_waiting", {30'd0, b_trap, b_imem_req}, 32'd1);
      end
      step(); chk("to_trap", {29'd0, b_trap, b_trap_cause}, {29'd0, 1'b1, 2'b10});
      chk("to_noreq", {31'd0, b_imem_req}, 32'd0);
      step(); chk("to_hold", {30'd0, b_trap, b_imem_req}, 32'd2);
      rst4 = 1'b0;
      #2 rst4 = 1'b1;
      chk("to_rst", {31'd0, b_trap}, 32'd0);
      repeat (4) step();
      imem_ready4 = 1'b1;
      #1 chk("to_late_irw", {31'd0, b_IRWrite}, 32'd1);
      step(); chk("to_late_ok", {29'd0, b_trap, b_ALUSrcB}, {29'd0, 1'b0, 2'b11});

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/mc_ctrl_hs.md
Name: mc_ctrl_hs

Overview:
Next-generation multicycle main control FSM for the MIPS datapath, replacing the fixed-timing controller. It adds a req/ready handshake to instruction and data memory, so memories may insert wait states. It also adds a bus-timeout watchdog, illegal-opcode trapping and a retired-instruction counter. Driven by IR opcode/funct, it drives every datapath mux/enable on the existing encodings.

Parameters:
MEM_TIMEOUT, 16, wait cycles allowed for any memory ready before a bus-timeout trap (1..255)
CNT_W, 32, width of instret counter
ALUOP_W, 4, width of ALUOp bus

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-low
op  in  6  IR[31:26]
funct  in  6  IR[5:0]
imem_ready  in  1  instruction word valid this cycle
dmem_ready  in  1  data access complete / read data valid this cycle
imem_req  out  1  instruction fetch request, level
dmem_req  out  1  data access request, level
IRWrite, PCWrite, PCWriteCond, MemWrite, RegWrite, extop, dmEXTop  out  1 each  datapath enables/selects
PCSource, ALUSrcA, ALUSrcB, MemtoReg, RegDst, lsop  out  2 each  mux selects
ALUOp  out  ALUOP_W  ALU operation class
trap  out  1  core halted
trap_cause  out  2  01 illegal opcode, 10 bus timeout, 00 none
instret  out  CNT_W  retired instruction count

Behaviour:
- Mux encodings: RegDst 00 rt / 01 rd / 10 $31. ALUSrcA 00 PC / 01 A / 10 A+shamt. ALUSrcB 00 B / 01 4 / 10 ext / 11 ext<<2. PCSource 00 ALU / 01 ALUOut / 10 jump target. MemtoReg 00 ALUOut / 01 MDR / 10 PC. lsop 00 word / 01 half / 10 byte. extop and dmEXTop: 1 = sign-extend.
- rst low: state IDLE, wait counter 0, instret 0, trap 0, trap_cause 00. All outputs are Moore decodes of state; in IDLE every output is 0. IDLE goes to FETCH unconditionally on the first edge after release.
- FETCH: imem_req=1, ALUSrcA=00, ALUSrcB=01, ALUOp=ADD, PCSource=00. IRWrite and PCWrite assert only while imem_ready=1. If ready is high in the first FETCH cycle, the fetch has zero wait states. On ready, go to DECODE.
- DECODE: ALUSrcA=00, ALUSrcB=11, ALUOp=ADD, so ALUOut holds the branch target. Dispatch on op. Any unlisted op, or R-type with an unlisted funct, goes to TRAP with cause 01.
- R-type (op 00; funct add/addu/sub/subu/and/or/xor/nor/slt/sltu/sll/srl/sra):
  - EXEC_R: ALUSrcA=01, or 10 for sll/srl/sra; ALUSrcB=00; ALUOp=FUNCT.
  - WB_R: RegWrite, RegDst=01, MemtoReg=00.
- jr (op 00, funct 08): JR state: ALUSrcA=01, ALUSrcB=00, ALUOp=ADD, PCSource=00, PCWrite.
- I-ALU (addi 08, addiu 09, slti 0A, sltiu 0B, andi 0C, ori 0D, xori 0E, lui 0F):
  - EXEC_I: ALUSrcA=01, ALUSrcB=10, ALUOp per op.
  - extop=1 for 08/09/0A/0B, 0 otherwise.
  - WB_I: RegWrite, RegDst=00, MemtoReg=00.
- Loads/stores (lw 23, lh 21, lhu 25, lb 20, lbu 24; sw 2B, sh 29, sb 28):
  - MEM_ADDR: ALUSrcA=01, ALUSrcB=10, extop=1, ALUOp=ADD.
  - Loads go to MEM_RD, then MEM_WB. Stores go to MEM_WR.
  - MEM_RD and MEM_WR assert dmem_req and hold lsop. MEM_WR also asserts MemWrite.
  - Each waits for dmem_ready, and the state is left on the ready cycle.
  - MEM_WB: RegWrite, RegDst=00, MemtoReg=01. dmEXTop=1 for lh/lb, 0 for lhu/lbu.
- beq (04): BRANCH state: ALUSrcA=01, ALUSrcB=00, ALUOp=SUB, PCWriteCond, PCSource=01.
- j (02): JUMP state: PCWrite, PCSource=10.
- jal (03): JAL state: PCWrite, PCSource=10, RegWrite, RegDst=10, MemtoReg=10. The old PC+4 is written in the same edge.
- Every terminal state (WB_R, WB_I, MEM_WB, MEM_WR on ready, BRANCH, JUMP, JAL, JR) returns to FETCH and increments instret by 1. instret wraps modulo 2^CNT_W.
- Wait counter:
  - Clears on entry to FETCH, MEM_RD and MEM_WR.
  - Increments each cycle that the waited-for ready is low.
  - When the count reaches MEM_TIMEOUT with ready still low, go to TRAP with cause 10, and drop the req.
  - Ready arriving in the same cycle the count reaches MEM_TIMEOUT wins: no trap.
- TRAP: all datapath outputs 0, trap=1, trap_cause held. TRAP is absorbing; only rst leaves it.
- rst asserted mid-access: req drops immediately (asynchronous), and no partial write enable survives.

Decomposition:
- Package mc_pkg:
  - state enum;
  - opcode and funct localparams;
  - ALUOp codes: ADD=0, SUB=1, FUNCT=2, AND=3, OR=4, XOR=5, LUI=6, SLT=7, SLTU=8;
  - mux select codes;
  - trap cause codes.
- One sub-module, mc_wait_timer: clear, count-while-waiting and expiry flag, parametrised by MEM_TIMEOUT.

Test Plan:
- rst low for 3 cycles, release, imem_ready=1 constantly, R-type add -> IDLE 1 cycle, then FETCH, DECODE, EXEC_R, WB_R; RegDst=01 in WB_R; instret=1 after 4 instruction cycles.
- lw with dmem_ready low for 5 cycles in MEM_RD -> dmem_req held 6 cycles; MEM_WB one cycle with MemtoReg=01, dmEXTop=1 only for lh/lb variants; instret increments once.
- MEM_TIMEOUT=4, imem_ready never asserted -> trap=1, trap_cause=10 exactly 4 cycles after entering FETCH; imem_req=0 thereafter; ready asserted on the 4th cycle instead -> no trap.
- op=3F -> TRAP with cause 01 after DECODE; all enables 0; state held until rst pulse, which returns outputs to 0 and instret to 0.
- jal then beq with Zero: JAL cycle shows PCWrite=1, RegWrite=1, RegDst=10, MemtoReg=10, PCSource=10; BRANCH shows PCWriteCond=1, PCSource=01, ALUOp=SUB.
- rst dropped during MEM_WR with dmem_ready low -> MemWrite and dmem_req fall in the same cycle without a clock edge; FETCH resumes after release.
